count_bcd_conv: RTL

COUNT_BCD_CONV -- requirements
Module: count_bcd_conv

---
 rtl/count_bcd_conv.sv | 97 +++++++++
 1 files changed

// File: rtl/count_bcd_conv.sv
// Serial binary-to-BCD converter (double dabble) for the 10..40 counter.
// One conversion takes eight SHIFT cycles followed by a one-cycle DONE.
module count_bcd_conv #(
  parameter logic [7:0] LO = 8'd10,
  parameter logic [7:0] HI = 8'd40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       in_range
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  shreg;
  logic [7:0]  opnd;
  logic [11:0] scr;
  logic [11:0] scr_adj;
  logic [11:0] scr_fin;
  logic [2:0]  iter;
  logic        load;
  logic        last;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    scr_adj = {adj(scr[11:8]), adj(scr[7:4]), adj(scr[3:0])};
    scr_fin = {scr_adj[10:0], shreg[7]};
    load    = start && (state != SHIFT);
    last    = (state == SHIFT) && (iter == 3'd7);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (iter == 3'd7) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // opnd keeps the captured value for the range check while shreg drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      opnd  <= '0;
      scr   <= '0;
      iter  <= '0;
    end else if (load) begin
      shreg <= count;
      opnd  <= count;
      scr   <= '0;
      iter  <= '0;
    end else if (state == SHIFT) begin
      {scr, shreg} <= {scr_adj[10:0], shreg, 1'b0};
      iter         <= iter + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_hund <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      in_range <= 1'b0;
    end else if (last) begin
      bcd_hund <= scr_fin[11:8];
      bcd_tens <= scr_fin[7:4];
      bcd_ones <= scr_fin[3:0];
      in_range <= (opnd >= LO) && (opnd <= HI);
    end
  end

endmodule
